l2_arbiter: RTL and testbench

Two-to-one arbiter between the split L1 caches (instruction and data) and the unified L2 cache. It is the initiator on the L2 request interface (L2_read / L2_write / L2_address / L2_wdata, answered by L2_resp / L2_rdata) and the responder to each L1's miss / writeback interface. Each request is captured into registers on grant and held stable until the L2 responds. When both L1s contend, round-robin priority guarantees neither starves.

---
 rtl/l2_arbiter.sv | 94 +++++++++
 tb/tb_l2_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Two-to-one round-robin arbiter between the split L1 caches and the unified L2.
// A granted request is captured into registers and held until the L2 responds.
module l2_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         icache_read,
  input  logic [15:0]  icache_address,
  output logic         icache_resp,
  output logic [127:0] icache_rdata,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [15:0]  dcache_address,
  input  logic [127:0] dcache_wdata,
  output logic         dcache_resp,
  output logic [127:0] dcache_rdata,
  output logic         L2_read,
  output logic         L2_write,
  output logic [15:0]  L2_address,
  output logic [127:0] L2_wdata,
  input  logic         L2_resp,
  input  logic [127:0] L2_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic [15:0]  req_addr_q, req_addr_d;
  logic [127:0] req_wdata_q, req_wdata_d;
  logic         req_is_write_q, req_is_write_d;

  logic i_req, d_req, serving;

  assign i_req   = icache_read;
  assign d_req   = dcache_read | dcache_write;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_is_write_d = req_is_write_q;
    case (state_q)
      IDLE: begin
        // On a tie, the port not granted last time wins (last_grant_q=1 means D went last).
        if (i_req && (!d_req || last_grant_q)) begin
          state_d        = SERVE_I;
          last_grant_d   = 1'b0;
          req_addr_d     = icache_address;
          req_is_write_d = 1'b0;
        end else if (d_req) begin
          state_d        = SERVE_D;
          last_grant_d   = 1'b1;
          req_addr_d     = dcache_address;
          req_wdata_d    = dcache_wdata;
          req_is_write_d = dcache_write;
        end
      end
      SERVE_I, SERVE_D: begin
        if (L2_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_is_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_is_write_q <= req_is_write_d;
    end
  end

  assign L2_read      = serving & ~req_is_write_q;
  assign L2_write     = serving &  req_is_write_q;
  assign L2_address   = req_addr_q;
  assign L2_wdata     = req_wdata_q;
  assign icache_resp  = (state_q == SERVE_I) & L2_resp;
  assign dcache_resp  = (state_q == SERVE_D) & L2_resp;
  assign icache_rdata = L2_rdata;
  assign dcache_rdata = L2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: reset, lone fill, writeback, round-robin, stray resp, reset mid-serve, illegal read+write.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         icache_read;
  logic [15:0]  icache_address;
  logic         icache_resp;
  logic [127:0] icache_rdata;
  logic         dcache_read;
  logic         dcache_write;
  logic [15:0]  dcache_address;
  logic [127:0] dcache_wdata;
  logic         dcache_resp;
  logic [127:0] dcache_rdata;
  logic         L2_read;
  logic         L2_write;
  logic [15:0]  L2_address;
  logic [127:0] L2_wdata;
  logic         L2_resp;
  logic [127:0] L2_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] RDATA = 128'hDEAD_0102_0304_0506_0708_090A_0B0C_BEEF;
  localparam logic [127:0] WDATA = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

  l2_arbiter dut (
    .clk(clk), .reset(reset),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_resp(icache_resp), .icache_rdata(icache_rdata),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
    .L2_read(L2_read), .L2_write(L2_write),
    .L2_address(L2_address), .L2_wdata(L2_wdata),
    .L2_resp(L2_resp), .L2_rdata(L2_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_read = 0; icache_address = '0;
    dcache_read = 0; dcache_write = 0; dcache_address = '0; dcache_wdata = '0;
    L2_resp = 0; L2_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    n_checks++; if ({L2_read, L2_write} !== 2'b00) $display("FAIL reset_rw: got %b expected 00", {L2_read, L2_write}); else n_pass++;
    n_checks++; if (L2_address !== 16'h0) $display("FAIL reset_addr: got %h expected 0000", L2_address); else n_pass++;
    n_checks++; if (L2_wdata !== 128'h0) $display("FAIL reset_wdata: got %h expected 0", L2_wdata); else n_pass++;
    L2_resp = 1; #1;
    n_checks++; if ({icache_resp, dcache_resp} !== 2'b00) $display("FAIL reset_resp: got %b expected 00", {icache_resp, dcache_resp}); else n_pass++;
    L2_resp = 0;
    tick();
  endtask

  task automatic test_lone_ifill();
    int pulses;
    icache_read = 1; icache_address = 16'h1230;
    #1;
    n_checks++; if (L2_read !== 1'b0) $display("FAIL ifill_req_cycle: got %b expected 0", L2_read); else n_pass++;
    tick();
    n_checks++; if (L2_read !== 1'b1 || L2_write !== 1'b0) $display("FAIL ifill_issue: got rd=%b wr=%b expected rd=1 wr=0", L2_read, L2_write); else n_pass++;
    n_checks++; if (L2_address !== 16'h1230) $display("FAIL ifill_addr: got %h expected 1230", L2_address); else n_pass++;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (icache_resp) pulses++;
      tick();
    end
    L2_resp = 1; L2_rdata = RDATA; #1;
    if (icache_resp) pulses++;
    n_checks++; if (icache_rdata !== RDATA) $display("FAIL ifill_rdata: got %h expected %h", icache_rdata, RDATA); else n_pass++;
    n_checks++; if (dcache_resp !== 1'b0) $display("FAIL ifill_dresp: got %b expected 0", dcache_resp); else n_pass++;
    tick();
    L2_resp = 0; icache_read = 0; #1;
    if (icache_resp) pulses++;
    n_checks++; if (pulses !== 1) $display("FAIL ifill_resp_pulses: got %0d expected 1", pulses); else n_pass++;
    n_checks++; if (L2_read !== 1'b0) $display("FAIL ifill_idle_after: got %b expected 0", L2_read); else n_pass++;
    tick();
  endtask

  task automatic test_d_writeback();
    dcache_write = 1; dcache_address = 16'h4000; dcache_wdata = WDATA;
    tick();
    n_checks++; if (L2_write !== 1'b1 || L2_read !== 1'b0) $display("FAIL dwb_issue: got rd=%b wr=%b expected rd=0 wr=1", L2_read, L2_write); else n_pass++;
    n_checks++; if (L2_wdata !== WDATA) $display("FAIL dwb_wdata: got %h expected %h", L2_wdata, WDATA); else n_pass++;
    dcache_address = 16'hBEEF; dcache_wdata = ~WDATA;
    tick();
    n_checks++; if (L2_address !== 16'h4000) $display("FAIL dwb_addr_stable: got %h expected 4000", L2_address); else n_pass++;
    n_checks++; if (L2_wdata !== WDATA) $display("FAIL dwb_wdata_stable: got %h expected %h", L2_wdata, WDATA); else n_pass++;
    L2_resp = 1; #1;
    n_checks++; if (dcache_resp !== 1'b1 || icache_resp !== 1'b0) $display("FAIL dwb_resp: got d=%b i=%b expected d=1 i=0", dcache_resp, icache_resp); else n_pass++;
    tick();
    L2_resp = 0; dcache_write = 0; #1;
    n_checks++; if (L2_write !== 1'b0) $display("FAIL dwb_idle_after: got %b expected 0", L2_write); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'h1000; exp_addr[1] = 16'h2000; exp_addr[2] = 16'h1000; exp_addr[3] = 16'h2000;
    reset = 1; tick(); reset = 0;
    icache_read = 1; icache_address = 16'h1000;
    dcache_read = 1; dcache_address = 16'h2000;
    for (int g = 0; g < 4; g++) begin
      tick();
      n_checks++; if (L2_read !== 1'b1 || L2_address !== exp_addr[g]) $display("FAIL rr_grant%0d: got rd=%b addr=%h expected rd=1 addr=%h", g, L2_read, L2_address, exp_addr[g]); else n_pass++;
      L2_resp = 1; #1;
      n_checks++; if ({icache_resp, dcache_resp} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL rr_resp%0d: got i/d=%b expected %b", g, {icache_resp, dcache_resp}, (g % 2 == 0) ? 2'b10 : 2'b01); else n_pass++;
      tick();
      L2_resp = 0; #1;
      n_checks++; if (L2_read !== 1'b0) $display("FAIL rr_bubble%0d: got %b expected 0", g, L2_read); else n_pass++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_stray_resp();
    L2_resp = 1; #1;
    n_checks++; if ({icache_resp, dcache_resp} !== 2'b00) $display("FAIL stray_resp: got %b expected 00", {icache_resp, dcache_resp}); else n_pass++;
    tick();
    L2_resp = 0; #1;
    n_checks++; if ({L2_read, L2_write} !== 2'b00) $display("FAIL stray_state: got %b expected 00", {L2_read, L2_write}); else n_pass++;
    icache_read = 1; icache_address = 16'h0042;
    tick();
    n_checks++; if (L2_read !== 1'b1 || L2_address !== 16'h0042) $display("FAIL stray_regrant: got rd=%b addr=%h expected rd=1 addr=0042", L2_read, L2_address); else n_pass++;
    L2_resp = 1; tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_serve();
    dcache_write = 1; dcache_address = 16'h7770; dcache_wdata = WDATA;
    tick();
    n_checks++; if (L2_write !== 1'b1) $display("FAIL rms_serving: got %b expected 1", L2_write); else n_pass++;
    reset = 1;
    tick();
    reset = 0; dcache_write = 0;
    n_checks++; if ({L2_read, L2_write} !== 2'b00) $display("FAIL rms_rw: got %b expected 00", {L2_read, L2_write}); else n_pass++;
    n_checks++; if (L2_address !== 16'h0 || L2_wdata !== 128'h0) $display("FAIL rms_regs: got addr=%h wdata=%h expected 0", L2_address, L2_wdata); else n_pass++;
    icache_read = 1; icache_address = 16'h0A00;
    dcache_read = 1; dcache_address = 16'h0D00;
    tick();
    n_checks++; if (L2_read !== 1'b1 || L2_address !== 16'h0A00) $display("FAIL rms_tie_i: got rd=%b addr=%h expected rd=1 addr=0a00", L2_read, L2_address); else n_pass++;
    L2_resp = 1; tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_illegal_rw();
    reset = 1; tick(); reset = 0;
    dcache_read = 1; dcache_write = 1; dcache_address = 16'h5550; dcache_wdata = WDATA;
    tick();
    n_checks++; if (L2_write !== 1'b1 || L2_read !== 1'b0) $display("FAIL illegal_rw: got rd=%b wr=%b expected rd=0 wr=1", L2_read, L2_write); else n_pass++;
    L2_resp = 1; #1;
    n_checks++; if (dcache_resp !== 1'b1) $display("FAIL illegal_resp: got %b expected 1", dcache_resp); else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_lone_ifill();
    test_d_writeback();
    test_round_robin();
    test_stray_resp();
    test_reset_mid_serve();
    test_illegal_rw();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
